keypad_scan_ctrl: RTL and testbench

//  Parametrised matrix-keypad scanner: drives one row at a time, samples the

---
 rtl/keypad_scan_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner with frame-level debounce and a valid/ready key-event port.
// Optional seven-segment echo of the last accepted key is enabled by defining KEYPAD_SSD_EN.
module keypad_scan_ctrl #(
   parameter int ROWS           = 4,
   parameter int COLS           = 3,
   parameter int SCAN_DIV       = 208333,
   parameter int DEBOUNCE_SCANS = 4,
   localparam int KW            = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [COLS-1:0] col_in,
   output logic [ROWS-1:0] row_drv,
   output logic            key_valid,
   output logic [KW-1:0]   key_code,
   input  logic            key_ready,
   output logic            key_held,
   output logic            overrun
`ifdef KEYPAD_SSD_EN
   ,
   output logic [7:0]      dig,
   output logic [7:0]      ssd
`endif
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   logic [COLS-1:0] r_col_meta, r_col_sync;
   logic [PW-1:0]   r_presc;
   logic [RW-1:0]   r_row_idx;
   logic [ROWS-1:0] r_row_drv;
   logic            r_found;
   logic [KW-1:0]   r_found_code;
   state_t          r_state;
   logic [KW-1:0]   r_cand;
   logic [CW-1:0]   r_cnt;
   logic            r_key_valid, r_key_held, r_overrun;
   logic [KW-1:0]   r_key_code;

   logic            w_tick, w_last_row, w_frame, w_row_hit;
   logic [KW-1:0]   w_col_first, w_code_here, w_res_code;
   logic            w_acc_found, w_res_found, w_same_key, w_cnt_done, w_emit;

   // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col_meta <= '0;
         r_col_sync <= '0;
      end else begin
         r_col_meta <= col_in;
         r_col_sync <= r_col_meta;
      end
   end

   assign w_tick     = (r_presc == PW'(SCAN_DIV - 1));
   assign w_last_row = (r_row_idx == RW'(ROWS - 1));
   assign w_frame    = w_tick && w_last_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc   <= '0;
         r_row_idx <= '0;
         r_row_drv <= ROWS'(1);
      end else if (w_tick) begin
         r_presc <= '0;
         if (w_last_row) begin
            r_row_idx <= '0;
            r_row_drv <= ROWS'(1);
         end else begin
            r_row_idx <= r_row_idx + RW'(1);
            r_row_drv <= {r_row_drv[ROWS-2:0], 1'b0};
         end
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // NOTE: every signal driven here gets a default first, so no latch can be inferred.
   always_comb begin
      w_row_hit   = |r_col_sync;
      w_col_first = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (r_col_sync[c]) w_col_first = KW'(c);
      end
   end

   // Rows are scanned in ascending order, so the first hit in a frame is the lowest code.
   assign w_code_here = KW'(r_row_idx) * KW'(COLS) + w_col_first;
   assign w_acc_found = (r_row_idx != '0) && r_found;
   assign w_res_found = w_acc_found || w_row_hit;
   assign w_res_code  = w_acc_found ? r_found_code : w_code_here;
   assign w_same_key  = w_res_found && (w_res_code == r_cand);
   assign w_cnt_done  = (int'(r_cnt) + 1) >= DEBOUNCE_SCANS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_found      <= 1'b0;
         r_found_code <= '0;
      end else if (w_tick) begin
         r_found      <= w_res_found;
         r_found_code <= w_res_code;
      end
   end

   always_comb begin
      w_emit = 1'b0;
      if (w_frame) begin
         case (r_state)
            S_IDLE:     w_emit = w_res_found && (DEBOUNCE_SCANS == 1);
            S_DEBOUNCE: w_emit = w_same_key && w_cnt_done;
            default:    w_emit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cand      <= '0;
         r_cnt       <= '0;
         r_key_held  <= 1'b0;
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_frame) begin
            case (r_state)
               S_IDLE: begin
                  if (w_res_found) begin
                     r_cand <= w_res_code;
                     r_cnt  <= CW'(1);
                     if (DEBOUNCE_SCANS == 1) begin
                        r_state    <= S_PRESSED;
                        r_key_held <= 1'b1;
                     end else begin
                        r_state <= S_DEBOUNCE;
                     end
                  end
               end
               S_DEBOUNCE: begin
                  if (!w_res_found) begin
                     r_state <= S_IDLE;
                  end else if (w_same_key) begin
                     r_cnt <= r_cnt + CW'(1);
                     if (w_cnt_done) begin
                        r_state    <= S_PRESSED;
                        r_key_held <= 1'b1;
                     end
                  end else begin
                     r_cand <= w_res_code;
                     r_cnt  <= CW'(1);
                  end
               end
               S_PRESSED: begin
                  if (!w_same_key) begin
                     r_state <= S_RELEASE;
                     r_cnt   <= CW'(1);
                  end
               end
               default: begin
                  if (!w_res_found) begin
                     if (w_cnt_done) begin
                        r_state    <= S_IDLE;
                        r_key_held <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end else if (w_same_key) begin
                     r_state <= S_PRESSED;
                  end else begin
                     r_cnt <= CW'(1);
                  end
               end
            endcase
         end

         // A consumer stalling with an event pending loses the newer event, never the older one.
         if (w_emit && r_key_valid && !key_ready) begin
            r_overrun <= 1'b1;
         end else if (w_emit) begin
            r_key_valid <= 1'b1;
            r_key_code  <= w_res_code;
         end else if (r_key_valid && key_ready) begin
            r_key_valid <= 1'b0;
         end
      end
   end

   assign row_drv   = r_row_drv;
   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_held  = r_key_held;
   assign overrun   = r_overrun;

`ifdef KEYPAD_SSD_EN
   // Segment order {a,b,c,d,e,f,g,dp}, active-low; dp is always off.
   function automatic logic [7:0] glyph(input logic [KW-1:0] code);
      case (int'(code))
         0:       glyph = 8'b0000001_1;
         1:       glyph = 8'b1001111_1;
         2:       glyph = 8'b0010010_1;
         3:       glyph = 8'b0000110_1;
         4:       glyph = 8'b1001100_1;
         5:       glyph = 8'b0100100_1;
         6:       glyph = 8'b0100000_1;
         7:       glyph = 8'b0001111_1;
         8:       glyph = 8'b0000000_1;
         9:       glyph = 8'b0000100_1;
         10:      glyph = 8'b0001000_1;
         11:      glyph = 8'b1100000_1;
         12:      glyph = 8'b0110001_1;
         13:      glyph = 8'b1000010_1;
         14:      glyph = 8'b0110000_1;
         15:      glyph = 8'b0111000_1;
         default: glyph = 8'b1111110_1;
      endcase
   endfunction

   logic [7:0] r_ssd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ssd <= 8'hFF;
      end else if (r_key_valid && key_ready) begin
         r_ssd <= glyph(r_key_code);
      end
   end

   assign dig = 8'b0111_1111;
   assign ssd = r_ssd;
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad matrix model drives col_in from row_drv,
// expected key events are queued when presses are applied and popped on each handshake.
module tb_keypad_scan_ctrl;

   localparam int ROWS  = 4;
   localparam int COLS  = 3;
   localparam int KW    = 4;
   localparam int FRAME = 16;

   typedef struct {
      logic [ROWS*COLS-1:0] keys;
      int                   code;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [COLS-1:0] col_in;
   logic [ROWS-1:0] row_drv;
   logic            key_valid;
   logic [KW-1:0]   key_code;
   logic            key_ready = 1'b1;
   logic            key_held;
   logic            overrun;

   logic [ROWS*COLS-1:0] keys = '0;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   ovr_cnt;
   int   mon_exp;
   int   exp_q[$];
   vec_t vecs[6];

   always #5 clk = ~clk;

   keypad_scan_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .col_in   (col_in),
      .row_drv  (row_drv),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_ready(key_ready),
      .key_held (key_held),
      .overrun  (overrun)
   );

   // Pressed key at (r,c) connects row r to column c.
   always_comb begin
      col_in = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (keys[r*COLS+c] && row_drv[r]) col_in[c] = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   task automatic align();
      while (cyc % FRAME != 0) step(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_row_drv"},   32'(row_drv),   32'h1);
      check({tag, "_key_valid"}, 32'(key_valid), 32'h0);
      check({tag, "_key_code"},  32'(key_code),  32'h0);
      check({tag, "_key_held"},  32'(key_held),  32'h0);
      check({tag, "_overrun"},   32'(overrun),   32'h0);
   endtask

   always @(negedge clk) begin
      if (overrun) ovr_cnt++;
      if (key_valid && key_ready) begin
         check("event_expected", 32'(exp_q.size() != 0), 32'h1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("event_code", 32'(key_code), 32'(mon_exp));
         end
      end
   end

   initial begin
      vecs[0] = '{keys: 12'h080, code: 7};
      vecs[1] = '{keys: 12'h808, code: 3};
      vecs[2] = '{keys: 12'h001, code: 0};
      vecs[3] = '{keys: 12'h800, code: 11};
      vecs[4] = '{keys: 12'h006, code: 1};
      vecs[5] = '{keys: 12'h540, code: 6};

      step(3);
      check_reset_outputs("por");
      rst_n = 1'b1;
      cyc   = 0;

      // Idle scanning: one-hot row walks every 4 clocks, no events.
      for (int k = 0; k < 5*FRAME; k++) begin
         check("idle_row_drv", 32'(row_drv), 32'(1 << ((cyc / 4) % ROWS)));
         check("idle_key_valid", 32'(key_valid), 32'h0);
         step(1);
      end

      // Single presses and multi-key priority, consumer always ready.
      key_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         align();
         keys = vecs[i].keys;
         exp_q.push_back(vecs[i].code);
         step(4*FRAME);
         check("vec_held_after_press", 32'(key_held), 32'h1);
         check("vec_event_delivered", 32'(exp_q.size()), 32'h0);
         keys = '0;
         step(3*FRAME);
         check("vec_held_after_release", 32'(key_held), 32'h0);
      end

      // Bounce: on 2 frames, off 1, on 1, off -> no event.
      align();
      keys = 12'h001; step(2*FRAME);
      keys = 12'h000; step(FRAME);
      keys = 12'h001; step(FRAME);
      keys = 12'h000; step(2*FRAME);
      check("bounce_held", 32'(key_held), 32'h0);
      check("bounce_valid", 32'(key_valid), 32'h0);
      // A clean press afterwards needs exactly three fresh frames.
      keys = 12'h001;
      exp_q.push_back(0);
      step(3*FRAME - 1);
      check("after_bounce_not_yet", 32'(key_held), 32'h0);
      step(1);
      check("after_bounce_held", 32'(key_held), 32'h1);
      keys = '0;
      step(3*FRAME);

      // Stalled consumer: second event dropped with one overrun pulse.
      ovr_cnt   = 0;
      key_ready = 1'b0;
      align();
      keys = 12'h010;
      exp_q.push_back(4);
      step(4*FRAME);
      check("stall_valid_first", 32'(key_valid), 32'h1);
      keys = '0;
      step(3*FRAME);
      keys = 12'h200;
      step(4*FRAME);
      check("stall_overrun_count", 32'(ovr_cnt), 32'h1);
      check("stall_code_kept", 32'(key_code), 32'h4);
      check("stall_valid_kept", 32'(key_valid), 32'h1);
      check("stall_held_second", 32'(key_held), 32'h1);
      key_ready = 1'b1;
      step(1);
      check("stall_valid_cleared", 32'(key_valid), 32'h0);
      keys = '0;
      step(3*FRAME);
      check("stall_queue_drained", 32'(exp_q.size()), 32'h0);

      // Asynchronous reset mid-debounce, while on row 1.
      align();
      keys = 12'h020;
      step(2*FRAME + 6);
      check("mid_deb_row_before", 32'(row_drv), 32'h2);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid_debounce");
      keys = '0;
      step(1);
      rst_n = 1'b1;
      cyc   = 0;
      keys  = 12'h020;
      exp_q.push_back(5);
      step(3*FRAME - 1);
      check("post_rst_not_yet", 32'(key_held), 32'h0);
      step(1);
      check("post_rst_held", 32'(key_held), 32'h1);
      keys = '0;
      step(3*FRAME);

      // Asynchronous reset with an event pending: the event is lost.
      key_ready = 1'b0;
      align();
      keys = 12'h004;
      step(4*FRAME);
      check("pending_valid", 32'(key_valid), 32'h1);
      check("pending_code", 32'(key_code), 32'h2);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_pending");
      keys = '0;
      step(1);
      rst_n     = 1'b1;
      cyc       = 0;
      key_ready = 1'b1;
      step(2*FRAME);
      check("pending_lost", 32'(key_valid), 32'h0);

      check("final_queue_empty", 32'(exp_q.size()), 32'h0);
      check("final_overrun_total", 32'(ovr_cnt), 32'h1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
